rv_alu: RTL and testbench

RV_ALU -- requirements
Module: rv_alu

---
 rtl/rv_pkg.sv | 24 ++
 rtl/rv_alu_core.sv | 80 ++++++++
 rtl/rv_alu.sv | 40 ++++
 tb/tb_rv_alu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared ALU definitions: operand width and 4-bit op-codes.
// Imported by the ALU datapath and its registered wrapper.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLT  = 4'd1;
  localparam logic [3:0] ALU_SLTU = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SUB  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_LT   = 4'd12;
  localparam logic [3:0] ALU_GE   = 4'd13;
  localparam logic [3:0] ALU_LTU  = 4'd14;
  localparam logic [3:0] ALU_GEU  = 4'd15;

endpackage

// File: rtl/rv_alu_core.sv
// Combinational ALU datapath: one shared adder/subtractor
// feeds arithmetic, set-less-than and branch compares.
module rv_alu_core
  import rv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic [W-1:0] result,
  output logic         cmp
);

  logic         sub;
  logic [W:0]   sum;
  logic [W-1:0] diff;
  logic         ltu;
  logic         lt;
  logic         eq;
  logic [4:0]   shamt;

  assign sub   = (op != ALU_ADD);
  assign sum   = {1'b0, rs1}
               + {1'b0, (sub ? ~rs2 : rs2)}
               + {{W{1'b0}}, sub};
  assign diff  = sum[W-1:0];
  // carry out of rs1 + ~rs2 + 1 is set when rs1 >= rs2
  assign ltu   = ~sum[W];
  assign lt    = (rs1[W-1] != rs2[W-1]) ? rs1[W-1]
                                        : diff[W-1];
  assign eq    = (diff == '0);
  assign shamt = rs2[4:0];

  always_comb begin
    result = '0;
    cmp    = 1'b0;
    unique case (op)
      ALU_ADD:  result = diff;
      ALU_SLT:  result = {{(W-1){1'b0}}, lt};
      ALU_SLTU: result = {{(W-1){1'b0}}, ltu};
      ALU_AND:  result = rs1 & rs2;
      ALU_OR:   result = rs1 | rs2;
      ALU_XOR:  result = rs1 ^ rs2;
      ALU_SLL:  result = rs1 << shamt;
      ALU_SRL:  result = rs1 >> shamt;
      ALU_SRA:  result = W'($signed(rs1) >>> shamt);
      ALU_SUB:  result = diff;
      ALU_EQ: begin
        result = diff;
        cmp    = eq;
      end
      ALU_NE: begin
        result = diff;
        cmp    = ~eq;
      end
      ALU_LT: begin
        result = diff;
        cmp    = lt;
      end
      ALU_GE: begin
        result = diff;
        cmp    = ~lt;
      end
      ALU_LTU: begin
        result = diff;
        cmp    = ltu;
      end
      ALU_GEU: begin
        result = diff;
        cmp    = ~ltu;
      end
      default: begin
        result = '0;
        cmp    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_alu.sv
// Registered ALU: single-cycle latency, new op every cycle,
// synchronous active-high reset clears both outputs.
module rv_alu
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      op_in,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic            comp_res
);

  logic [XLEN-1:0] result;
  logic            cmp;

  rv_alu_core #(
    .W (XLEN)
  ) u_core (
    .op     (op_in),
    .rs1    (rs1),
    .rs2    (rs2),
    .result (result),
    .cmp    (cmp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd       <= '0;
      comp_res <= 1'b0;
    end else begin
      rd       <= result;
      comp_res <= cmp;
    end
  end

endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu: reference model plus
// directed vectors with hand-computed expectations.
module tb_rv_alu;

  logic        clk;
  logic        rst;
  logic [3:0]  op_in;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;
  logic        comp_res;

  int nvec;
  int nerr;

  logic [31:0] erd;
  logic        ecmp;
  bit          mvalid;

  rv_alu #(
    .XLEN (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_in    (op_in),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .comp_res (comp_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        c
  );
    int signed sa;
    int signed sb;
    int        sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b % 32);
    c  = 1'b0;
    r  = a - b;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd2:  r = (a < b) ? 32'd1 : 32'd0;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = a << sh;
      4'd7:  r = a >> sh;
      4'd8:  r = 32'(sa >>> sh);
      4'd9:  r = a - b;
      4'd10: c = (a == b);
      4'd11: c = (a != b);
      4'd12: c = (sa < sb);
      4'd13: c = (sa >= sb);
      4'd14: c = (a < b);
      default: c = (a >= b);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      erd  = '0;
      ecmp = 1'b0;
    end else begin
      model(op_in, rs1, rs2, erd, ecmp);
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      nvec++;
      if (rd !== erd || comp_res !== ecmp) begin
        nerr++;
        $display("FAIL model t=%0t rd=%h cmp=%b required rd=%h cmp=%b",
                 $time, rd, comp_res, erd, ecmp);
      end
    end
  end

  task automatic run(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        r
  );
    op_in = op;
    rs1   = a;
    rs2   = b;
    rst   = r;
    @(negedge clk);
  endtask

  task automatic chk(
    input string       name,
    input logic [31:0] er,
    input logic        ec
  );
    nvec++;
    if (rd !== er || comp_res !== ec) begin
      nerr++;
      $display("FAIL %s rd=%h cmp=%b required rd=%h cmp=%b",
               name, rd, comp_res, er, ec);
    end
  endtask

  initial begin
    nvec   = 0;
    nerr   = 0;
    mvalid = 1'b0;
    run(4'd0, $urandom, $urandom, 1'b1);
    run(4'd5, $urandom, $urandom, 1'b1);
    chk("reset", 32'h0, 1'b0);

    run(4'd0, 32'd5, 32'd7, 1'b0);
    chk("add_first", 32'd12, 1'b0);

    run(4'd1, 32'd1, 32'd1, 1'b0);
    chk("slt_eq", 32'd0, 1'b0);
    run(4'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("slt_neg", 32'd1, 1'b0);
    run(4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("sltu_big", 32'd0, 1'b0);

    run(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("add_wrap", 32'd0, 1'b0);
    run(4'd9, 32'd0, 32'd1, 1'b0);
    chk("sub_wrap", 32'hFFFF_FFFF, 1'b0);
    run(4'd5, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0);
    chk("xor", 32'h0F0F_0F0F, 1'b0);

    run(4'd8, 32'h8000_0000, 32'd31, 1'b0);
    chk("sra31", 32'hFFFF_FFFF, 1'b0);
    run(4'd7, 32'h8000_0000, 32'd31, 1'b0);
    chk("srl31", 32'd1, 1'b0);
    run(4'd6, 32'd1, 32'h25, 1'b0);
    chk("sll_mask", 32'h20, 1'b0);
    run(4'd6, 32'hA5A5_1234, 32'hFFFF_FFE0, 1'b0);
    chk("sll_zero", 32'hA5A5_1234, 1'b0);
    run(4'd8, 32'h4000_0000, 32'd30, 1'b0);
    chk("sra_pos", 32'd1, 1'b0);

    run(4'd12, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    chk("lt", 32'd1, 1'b1);
    run(4'd13, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    chk("ge", 32'd1, 1'b0);
    run(4'd14, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    chk("ltu", 32'd1, 1'b0);
    run(4'd15, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    chk("geu", 32'd1, 1'b1);
    run(4'd10, 32'd3, 32'd3, 1'b0);
    chk("eq", 32'd0, 1'b1);
    run(4'd11, 32'd3, 32'd3, 1'b0);
    chk("ne", 32'd0, 1'b0);
    run(4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    chk("and", 32'h0F00_0F00, 1'b0);
    run(4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    chk("hold", 32'h0F00_0F00, 1'b0);
    run(4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    chk("or", 32'hFFF0_FFF0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run(4'(i), $urandom, (i % 3 == 0) ? 32'h8000_0000 : $urandom,
          (i == 8));
      if (i == 8) chk("mid_reset", 32'h0, 1'b0);
    end
    run(4'd0, 32'd100, 32'd23, 1'b0);
    chk("after_b2b", 32'd123, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
